// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read ports, writeback
// port, issue port and the status outputs. The design end takes the slave modport.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   addr_rs1;
    logic [AW-1:0]   addr_rs2;
    logic [XLEN-1:0] data_rs1;
    logic [XLEN-1:0] data_rs2;
    logic [AW-1:0]   addr_rd;
    logic [XLEN-1:0] data_rd;
    logic            write_enable;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rs1_pending;
    logic            rs2_pending;
    logic            init_done;
    logic            state_dbg;

    // No handshake: write_enable and issue_valid are single-cycle strobes taken
    // at the rising edge only while init_done=1. There is no ready signal; reads
    // and pending flags are combinational and valid in the cycle the address is presented.
    modport slave (
        input  addr_rs1, addr_rs2, addr_rd, data_rd, write_enable, issue_valid, issue_rd,
        output data_rs1, data_rs2, rs1_pending, rs2_pending, init_done, state_dbg
    );

    modport master (
        output addr_rs1, addr_rs2, addr_rd, data_rd, write_enable, issue_valid, issue_rd,
        input  data_rs1, data_rs2, rs1_pending, rs2_pending, init_done, state_dbg
    );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with a post-reset hardware clear, optional same-cycle
// writeback bypass, and a per-register pending scoreboard for hazard stalls.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_sb_if.slave  bus
);
    localparam int            AW     = $clog2(NREGS);
    localparam logic [AW-1:0] LAST   = AW'(NREGS - 1);
    localparam bit            FWD_EN = (BYPASS != 0);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [NREGS-1:0] pending;
    logic            init_done_q;
    logic [XLEN-1:0] regs [NREGS];

    logic ready;
    logic wr_ok;
    logic iss_ok;
    logic fwd1;
    logic fwd2;

    assign ready  = (state == READY);
    assign wr_ok  = ready && bus.write_enable && (bus.addr_rd != '0);
    assign iss_ok = ready && bus.issue_valid && (bus.issue_rd != '0);
    // wr_ok already excludes x0, so a forward never targets a zero-address read.
    assign fwd1   = FWD_EN && wr_ok && (bus.addr_rd == bus.addr_rs1);
    assign fwd2   = FWD_EN && wr_ok && (bus.addr_rd == bus.addr_rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            pending     <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == LAST) begin
                        state       <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    if (wr_ok) pending[bus.addr_rd] <= 1'b0;
                    // Later assignment wins: a same-register issue marks a newer producer.
                    if (iss_ok) pending[bus.issue_rd] <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready)     regs[clr_cnt]     <= '0;
            else if (wr_ok) regs[bus.addr_rd] <= bus.data_rd;
        end
    end

    always_comb begin
        bus.data_rs1    = '0;
        bus.data_rs2    = '0;
        bus.rs1_pending = 1'b0;
        bus.rs2_pending = 1'b0;
        if (ready && (bus.addr_rs1 != '0)) begin
            bus.data_rs1    = fwd1 ? bus.data_rd : regs[bus.addr_rs1];
            bus.rs1_pending = pending[bus.addr_rs1] && !fwd1;
        end
        if (ready && (bus.addr_rs2 != '0)) begin
            bus.data_rs2    = fwd2 ? bus.data_rd : regs[bus.addr_rs2];
            bus.rs2_pending = pending[bus.addr_rs2] && !fwd2;
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one BYPASS=1 and one BYPASS=0 instance share stimulus;
// expected outputs are queued by the driver and checked by a negedge monitor.
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic            init;
        logic [XLEN-1:0] d1a;
        logic [XLEN-1:0] d2a;
        logic            p1a;
        logic            p2a;
        logic [XLEN-1:0] d1b;
        logic [XLEN-1:0] d2b;
        logic            p1b;
        logic            p2b;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]   rs1 = '0, rs2 = '0, ard = '0, ird = '0;
    logic [XLEN-1:0] dr = '0;
    logic            we = 1'b0, iv = 1'b0;

    reg_file_sb_if #(.XLEN(XLEN), .AW(AW)) bus_a ();
    reg_file_sb_if #(.XLEN(XLEN), .AW(AW)) bus_b ();

    assign bus_a.addr_rs1 = rs1;  assign bus_b.addr_rs1 = rs1;
    assign bus_a.addr_rs2 = rs2;  assign bus_b.addr_rs2 = rs2;
    assign bus_a.addr_rd = ard;   assign bus_b.addr_rd = ard;
    assign bus_a.data_rd = dr;    assign bus_b.data_rd = dr;
    assign bus_a.write_enable = we;  assign bus_b.write_enable = we;
    assign bus_a.issue_valid = iv;   assign bus_b.issue_valid = iv;
    assign bus_a.issue_rd = ird;     assign bus_b.issue_rd = ird;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           passed = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        we = 1'b0; iv = 1'b0; ard = '0; ird = '0; dr = '0;
        rs1 = a1; rs2 = a2;
    endtask

    task automatic expect_both(input string nm, input logic init,
                               input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                               input logic p1, input logic p2);
        exp_t e;
        e = '{init, d1, d2, p1, p2, d1, d2, p1, p2};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_split(input string nm,
                                input logic [XLEN-1:0] d1a, input logic [XLEN-1:0] d2a,
                                input logic p1a, input logic p2a,
                                input logic [XLEN-1:0] d1b, input logic [XLEN-1:0] d2b,
                                input logic p1b, input logic p2b);
        exp_t e;
        e = '{1'b1, d1a, d2a, p1a, p2a, d1b, d2b, p1b, p2b};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  act;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act.init = bus_a.init_done & bus_b.init_done;
            if (bus_a.init_done != bus_b.init_done) act.init = 1'bx;
            act.d1a = bus_a.data_rs1;  act.d2a = bus_a.data_rs2;
            act.p1a = bus_a.rs1_pending; act.p2a = bus_a.rs2_pending;
            act.d1b = bus_b.data_rs1;  act.d2b = bus_b.data_rs2;
            act.p1b = bus_b.rs1_pending; act.p2b = bus_b.rs2_pending;
            total++;
            if (act === e) passed++;
            else $display("FAIL %s got=%h exp=%h", nm, act, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset for 2 edges, then the 32-edge clear with writes/issues pulsed that must be ignored.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            idle(AW'(k), AW'(NREGS - 1 - k));
            if (k % 2 == 0) begin
                we = 1'b1; ard = AW'(5); dr = 32'hFFFF_FFFF;
                iv = 1'b1; ird = AW'(5);
            end
            expect_both($sformatf("clear_k%0d", k), 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        idle(AW'(5), AW'(5));
        expect_both("ready_x5_zero", 1'b1, '0, '0, 1'b0, 1'b0);
        tick();

        // Write x5 with same-cycle read on port 1.
        idle(AW'(5), AW'(0));
        we = 1'b1; ard = AW'(5); dr = 32'hDEAD_BEEF;
        expect_split("wr_x5_bypass", 32'hDEAD_BEEF, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        idle(AW'(5), AW'(5));
        expect_both("rd_x5_both", 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();

        // Write to x0 is discarded, never forwarded.
        idle(AW'(0), AW'(0));
        we = 1'b1; ard = AW'(0); dr = 32'h0000_1234;
        expect_both("wr_x0_fwd", 1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        idle(AW'(0), AW'(5));
        expect_both("rd_x0", 1'b1, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();

        // Bypass vs no bypass on x7.
        idle(AW'(7), AW'(5));
        we = 1'b1; ard = AW'(7); dr = 32'hA5A5_A5A5;
        expect_split("bypass_x7", 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 1'b0,
                     '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        idle(AW'(7), AW'(7));
        expect_both("rd_x7", 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0);
        tick();

        // Scoreboard: issue x9, then writeback x9.
        idle(AW'(9), AW'(9));
        iv = 1'b1; ird = AW'(9);
        expect_both("issue_x9_same_cycle", 1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        idle(AW'(7), AW'(9));
        expect_both("pend_x9", 1'b1, 32'hA5A5_A5A5, '0, 1'b0, 1'b1);
        tick();
        idle(AW'(7), AW'(9));
        we = 1'b1; ard = AW'(9); dr = 32'h0000_0099;
        expect_split("wb_x9_fwd", 32'hA5A5_A5A5, 32'h0000_0099, 1'b0, 1'b0,
                     32'hA5A5_A5A5, '0, 1'b0, 1'b1);
        tick();
        idle(AW'(9), AW'(9));
        expect_both("x9_cleared", 1'b1, 32'h0000_0099, 32'h0000_0099, 1'b0, 1'b0);
        tick();
        idle(AW'(0), AW'(9));
        iv = 1'b1; ird = AW'(0);
        tick();
        idle(AW'(0), AW'(9));
        expect_both("issue_x0", 1'b1, '0, 32'h0000_0099, 1'b0, 1'b0);
        tick();

        // Set wins over clear on the same register.
        idle(AW'(3), AW'(2));
        iv = 1'b1; ird = AW'(3);
        tick();
        idle(AW'(3), AW'(2));
        we = 1'b1; ard = AW'(3); dr = 32'h0000_0033;
        iv = 1'b1; ird = AW'(3);
        expect_split("wb_issue_x3", 32'h0000_0033, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        idle(AW'(3), AW'(2));
        expect_both("x3_still_pend", 1'b1, 32'h0000_0033, '0, 1'b1, 1'b0);
        tick();

        // Independent issue x4 and writeback x6 in one cycle.
        idle(AW'(4), AW'(6));
        iv = 1'b1; ird = AW'(6);
        tick();
        idle(AW'(4), AW'(6));
        we = 1'b1; ard = AW'(6); dr = 32'h0000_0066;
        iv = 1'b1; ird = AW'(4);
        expect_split("issue4_wb6", '0, 32'h0000_0066, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        idle(AW'(4), AW'(6));
        expect_both("after_4_6", 1'b1, '0, 32'h0000_0066, 1'b1, 1'b0);
        tick();

        // Write to a non-pending register leaves it clear.
        idle(AW'(0), AW'(0));
        we = 1'b1; ard = AW'(10); dr = 32'h0000_0010;
        tick();
        idle(AW'(10), AW'(0));
        expect_both("nonpend_x10", 1'b1, 32'h0000_0010, '0, 1'b0, 1'b0);
        tick();

        // Mid-operation reset restarts the clear.
        idle(AW'(9), AW'(5));
        iv = 1'b1; ird = AW'(9);
        tick();
        idle(AW'(9), AW'(5));
        expect_both("pre_reset", 1'b1, 32'h0000_0099, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            idle(AW'(9), AW'(5));
            expect_both($sformatf("reclear_k%0d", k), 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        idle(AW'(9), AW'(5));
        expect_both("reready", 1'b1, '0, '0, 1'b0, 1'b0);
        tick();

        tick();
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain got=%0d left exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
